// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron host sequencer and the neuron core:
// neuron state codes and the sequencer FSM encoding.
package lif_pkg;

  // State codes on the neuron's 2-bit control bus; the core decodes the same values.
  localparam logic [1:0] NRN_IDLE   = 2'b00;
  localparam logic [1:0] NRN_BETA   = 2'b01;
  localparam logic [1:0] NRN_THRESH = 2'b10;
  localparam logic [1:0] NRN_READ   = 2'b11;

  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE    = 3'd0;
  localparam fsm_state_t ST_CFG_THR = 3'd1;
  localparam fsm_state_t ST_RUN     = 3'd2;
  localparam fsm_state_t ST_FLUSH   = 3'd3;
  localparam fsm_state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/lif_spike_stats.sv
// Saturating step and spike counters plus first-spike timestep capture,
// sampled once per neuron READ cycle.
module lif_spike_stats #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic             spike,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] spike_count,
  output logic [CNT_W-1:0] first_spike_step
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // All-ones in first_spike_step doubles as "no spike yet"; a first spike
  // arriving after step_count saturates is therefore indistinguishable from none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count       <= '0;
      spike_count      <= '0;
      first_spike_step <= CNT_MAX;
    end else if (clear) begin
      step_count       <= '0;
      spike_count      <= '0;
      first_spike_step <= CNT_MAX;
    end else if (sample_en) begin
      if (step_count != CNT_MAX) begin
        step_count <= step_count + 1'b1;
      end
      if (spike) begin
        if (spike_count != CNT_MAX) begin
          spike_count <= spike_count + 1'b1;
        end
        if (first_spike_step == CNT_MAX) begin
          first_spike_step <= step_count;
        end
      end
    end
  end

endmodule

// File: rtl/lif_sequencer.sv
// Host-side sequencer for the LIF neuron core: turns a beta/threshold/stimulus
// byte stream into registered neuron state/data and collects spike statistics.
module lif_sequencer
  import lif_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             abort,
  output logic [1:0]       nrn_state,
  output logic [7:0]       nrn_data,
  input  logic             nrn_spike,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] spike_count,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] first_spike_step
);

  fsm_state_t state;
  logic       flush_sent;
  logic       accept;
  logic       stats_clear;
  logic       sample_en;

  // Abort wins over a simultaneous byte, so the byte is refused rather than
  // consumed and lost.
  always_comb begin
    // NOTE: default first so every path assigns in_ready and no latch is inferred.
    in_ready = 1'b0;
    case (state)
      ST_IDLE:            in_ready = 1'b1;
      ST_CFG_THR, ST_RUN: in_ready = !abort;
      default:            in_ready = 1'b0;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign stats_clear = (state == ST_IDLE) && accept;
  assign sample_en   = (nrn_state == NRN_READ);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);

  // Outputs are registered: a byte accepted at one edge is what the neuron sees
  // during the following cycle. Entering DONE always drives 00 to clear the neuron.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      nrn_state  <= NRN_IDLE;
      nrn_data   <= '0;
      err        <= 1'b0;
      flush_sent <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err <= in_last;
            if (in_last) begin
              state     <= ST_DONE;
              nrn_state <= NRN_IDLE;
              nrn_data  <= '0;
            end else begin
              state     <= ST_CFG_THR;
              nrn_state <= NRN_BETA;
              nrn_data  <= in_data;
            end
          end
        end

        // A stall leaves BETA and the beta byte in place; dropping to 00 here
        // would clear the neuron mid-configuration.
        ST_CFG_THR: begin
          if (abort) begin
            state     <= ST_DONE;
            nrn_state <= NRN_IDLE;
            nrn_data  <= '0;
          end else if (accept) begin
            if (in_last) begin
              err       <= 1'b1;
              state     <= ST_DONE;
              nrn_state <= NRN_IDLE;
              nrn_data  <= '0;
            end else begin
              state     <= ST_RUN;
              nrn_state <= NRN_THRESH;
              nrn_data  <= in_data;
            end
          end
        end

        // Before the first stimulus the threshold is simply held; afterwards a
        // stall becomes a zero-current READ bubble that still counts as a step.
        ST_RUN: begin
          if (abort) begin
            state     <= ST_DONE;
            nrn_state <= NRN_IDLE;
            nrn_data  <= '0;
          end else if (accept) begin
            nrn_state <= NRN_READ;
            nrn_data  <= in_data;
            if (in_last) begin
              state      <= ST_FLUSH;
              flush_sent <= 1'b0;
            end
          end else if (nrn_state == NRN_READ) begin
            nrn_data <= '0;
          end
        end

        // First FLUSH cycle still presents the last stimulus; it then issues one
        // READ/0x00 cycle so the final membrane update gets sampled.
        ST_FLUSH: begin
          if (abort || flush_sent) begin
            state     <= ST_DONE;
            nrn_state <= NRN_IDLE;
            nrn_data  <= '0;
          end else begin
            nrn_state  <= NRN_READ;
            nrn_data   <= '0;
            flush_sent <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state     <= ST_IDLE;
          nrn_state <= NRN_IDLE;
          nrn_data  <= '0;
        end
      endcase
    end
  end

  lif_spike_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (stats_clear),
    .sample_en       (sample_en),
    .spike           (nrn_spike),
    .step_count      (step_count),
    .spike_count     (spike_count),
    .first_spike_step(first_spike_step)
  );

endmodule

// File: tb/tb_lif_sequencer.sv
// Self-checking bench for lif_sequencer: directed runs plus randomized runs,
// with the neuron's spike line driven from a per-run spike pattern.
module tb_lif_sequencer;
  import lif_pkg::*;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             abort;
  logic [1:0]       nrn_state;
  logic [7:0]       nrn_data;
  logic             nrn_spike;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] spike_count;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] first_spike_step;

  always #5 clk = ~clk;

  lif_sequencer #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .abort           (abort),
    .nrn_state       (nrn_state),
    .nrn_data        (nrn_data),
    .nrn_spike       (nrn_spike),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .spike_count     (spike_count),
    .step_count      (step_count),
    .first_spike_step(first_spike_step)
  );

  int         total = 0;
  int         bad   = 0;
  bit         pat  [0:1023];
  logic [7:0] stim [0:511];
  int         rd_idx;
  logic       rdy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, play the neuron's spike for this READ step,
  // capture in_ready before the edge, then return 1 ns after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic a);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    abort    = a;
    if (nrn_state == NRN_READ) begin
      nrn_spike = pat[rd_idx % 1024];
      rd_idx++;
    end else begin
      nrn_spike = 1'($urandom_range(0, 1));
    end
    #1 rdy_seen = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    abort    = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic expect_nrn(input string tag, input logic [1:0] ns, input logic [7:0] nd);
    check({tag, ".state"}, nrn_state, ns);
    check({tag, ".data"}, nrn_data, nd);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic l,
                      input logic [1:0] ns, input logic [7:0] nd);
    step(1'b1, d, l, 1'b0);
    check({tag, ".ready"}, rdy_seen, 1'b1);
    expect_nrn(tag, ns, nd);
  endtask

  task automatic idle(input string tag, input logic [1:0] ns, input logic [7:0] nd);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    expect_nrn(tag, ns, nd);
  endtask

  // Expected statistics straight from the spike pattern of the planned READ steps.
  task automatic check_stats(input string tag, input int reads);
    int sc = 0;
    int fs = MAXC;
    for (int i = 0; i < reads; i++) begin
      if (pat[i]) begin
        sc++;
        if (fs == MAXC) fs = (i < MAXC) ? i : MAXC;
      end
    end
    check({tag, ".steps"}, step_count, (reads < MAXC) ? reads : MAXC);
    check({tag, ".spikes"}, spike_count, (sc < MAXC) ? sc : MAXC);
    check({tag, ".first"}, first_spike_step, fs);
  endtask

  // After the last stimulus: one flush READ/0x00, then DONE at 00 with a single done pulse.
  task automatic finish_run(input string tag, input int reads, input logic exp_err);
    step(1'b1, 8'h5a, 1'b0, 1'b0);
    check({tag, ".flush_ready"}, rdy_seen, 1'b0);
    expect_nrn({tag, ".flush"}, NRN_READ, 8'h00);
    check({tag, ".flush_done"}, done, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    expect_nrn({tag, ".end"}, NRN_IDLE, 8'h00);
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".err"}, err, exp_err);
    check_stats(tag, reads);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check({tag, ".done_ready"}, rdy_seen, 1'b0);
    check({tag, ".done_once"}, done, 1'b0);
    check({tag, ".idle_busy"}, busy, 1'b0);
    check_stats({tag, ".hold"}, reads);
  endtask

  task automatic run_seq(input string tag, input logic [7:0] beta, input logic [7:0] thr,
                         input int nstim, input int thr_stall, input int pre_stall,
                         input int bub_pos, input int bub_len, input bit rnd_bub);
    int reads = 0;
    int nb;
    rd_idx = 0;
    send({tag, ".beta"}, beta, 1'b0, NRN_BETA, beta);
    check({tag, ".clr_err"}, err, 1'b0);
    check({tag, ".clr_steps"}, step_count, 0);
    check({tag, ".clr_first"}, first_spike_step, MAXC);
    check({tag, ".busy"}, busy, 1'b1);
    repeat (thr_stall) idle({tag, ".beta_hold"}, NRN_BETA, beta);
    send({tag, ".thr"}, thr, 1'b0, NRN_THRESH, thr);
    repeat (pre_stall) idle({tag, ".thr_hold"}, NRN_THRESH, thr);
    for (int j = 0; j < nstim; j++) begin
      if (rnd_bub) nb = (j > 0) ? int'($urandom_range(0, 2)) : 0;
      else         nb = (j == bub_pos) ? bub_len : 0;
      repeat (nb) begin
        idle({tag, ".bubble"}, NRN_READ, 8'h00);
        reads++;
      end
      send({tag, ".stim"}, stim[j], (j == nstim - 1), NRN_READ, stim[j]);
      reads++;
    end
    finish_run(tag, reads + 1, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    abort     = 1'b0;
    nrn_spike = 1'b0;
    rd_idx    = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.state", nrn_state, NRN_IDLE);
    check("rst.data", nrn_data, 8'h00);
    check("rst.ready", in_ready, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.steps", step_count, 0);
    check("rst.spikes", spike_count, 0);
    check("rst.first", first_spike_step, MAXC);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic run: spike only on the flush step.
    for (int i = 0; i < 1024; i++) pat[i] = 1'b0;
    pat[3] = 1'b1;
    for (int j = 0; j < 3; j++) stim[j] = 8'd60;
    run_seq("basic", 8'd1, 8'd100, 3, 0, 0, 0, 0, 1'b0);

    // Zero threshold: spike on every READ step.
    for (int i = 0; i < 1024; i++) pat[i] = 1'b1;
    for (int j = 0; j < 2; j++) stim[j] = 8'd5;
    run_seq("allspk", 8'd0, 8'd0, 2, 0, 0, 0, 0, 1'b0);

    // Stalls before threshold, before first stimulus and mid-stimulus.
    for (int i = 0; i < 1024; i++) pat[i] = 1'($urandom);
    for (int j = 0; j < 3; j++) stim[j] = 8'd60;
    run_seq("stall", 8'd1, 8'd100, 3, 2, 1, 1, 2, 1'b0);

    // in_last on the threshold byte.
    rd_idx = 0;
    send("thrlast.beta", 8'd7, 1'b0, NRN_BETA, 8'd7);
    send("thrlast.thr", 8'd9, 1'b1, NRN_IDLE, 8'h00);
    check("thrlast.done", done, 1'b1);
    check("thrlast.err", err, 1'b1);
    check("thrlast.steps", step_count, 0);
    idle("thrlast.after", NRN_IDLE, 8'h00);
    check("thrlast.done_once", done, 1'b0);
    check("thrlast.err_sticky", err, 1'b1);

    // Abort with a byte offered on the second stimulus.
    for (int i = 0; i < 1024; i++) pat[i] = 1'($urandom);
    rd_idx = 0;
    send("abort.beta", 8'd3, 1'b0, NRN_BETA, 8'd3);
    check("abort.err_clr", err, 1'b0);
    send("abort.thr", 8'd50, 1'b0, NRN_THRESH, 8'd50);
    send("abort.stim0", 8'd33, 1'b0, NRN_READ, 8'd33);
    step(1'b1, 8'd44, 1'b0, 1'b1);
    check("abort.ready", rdy_seen, 1'b0);
    expect_nrn("abort.end", NRN_IDLE, 8'h00);
    check("abort.done", done, 1'b1);
    check("abort.err", err, 1'b0);
    check_stats("abort", 1);
    idle("abort.after", NRN_IDLE, 8'h00);
    check("abort.done_once", done, 1'b0);
    check("abort.busy", busy, 1'b0);

    // Abort in IDLE is ignored, including alongside a beta byte; abort in CFG_THR ends the run.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("idleabort.done", done, 1'b0);
    check("idleabort.busy", busy, 1'b0);
    check("idleabort.steps", step_count, 1);
    step(1'b1, 8'd21, 1'b0, 1'b1);
    check("idleabort.ready", rdy_seen, 1'b1);
    expect_nrn("idleabort.beta", NRN_BETA, 8'd21);
    check("idleabort.clr", step_count, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    expect_nrn("cfgabort.end", NRN_IDLE, 8'h00);
    check("cfgabort.done", done, 1'b1);
    idle("cfgabort.after", NRN_IDLE, 8'h00);

    // in_last on the beta byte.
    send("betalast", 8'd11, 1'b1, NRN_IDLE, 8'h00);
    check("betalast.done", done, 1'b1);
    check("betalast.err", err, 1'b1);
    idle("betalast.after", NRN_IDLE, 8'h00);

    // Saturation: 300 non-spiking stimuli.
    for (int i = 0; i < 1024; i++) pat[i] = 1'b0;
    for (int j = 0; j < 300; j++) stim[j] = 8'h01;
    run_seq("sat", 8'd0, 8'd255, 300, 0, 0, 0, 0, 1'b0);

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 10));
      for (int j = 0; j < n; j++) stim[j] = 8'($urandom);
      for (int i = 0; i < 1024; i++) pat[i] = 1'($urandom);
      run_seq("rnd", 8'($urandom), 8'($urandom), n, int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 0, 0, 1'b1);
    end

    // Reset in the middle of a run.
    rd_idx = 0;
    for (int i = 0; i < 1024; i++) pat[i] = 1'b1;
    send("midrst.beta", 8'd2, 1'b0, NRN_BETA, 8'd2);
    send("midrst.thr", 8'd8, 1'b0, NRN_THRESH, 8'd8);
    send("midrst.stim", 8'd77, 1'b0, NRN_READ, 8'd77);
    idle("midrst.bubble", NRN_READ, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.state", nrn_state, NRN_IDLE);
    check("midrst.data", nrn_data, 8'h00);
    check("midrst.busy", busy, 1'b0);
    check("midrst.ready", in_ready, 1'b1);
    check("midrst.steps", step_count, 0);
    check("midrst.spikes", spike_count, 0);
    check("midrst.first", first_spike_step, MAXC);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("midrst.after", NRN_IDLE, 8'h00);
    check("midrst.done", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
